axi_lite_slave_mem: RTL
=======================

// Module: axi_lite_slave_mem
// PURPOSE
//  AXI4-lite slave with an on-chip word-addressed memory. Sits directly downstream of the
//  CPU-side AXI4-lite master and terminates its AW/W/B/AR/R channels. Independent write and
//  read engines: one outstanding write and one outstanding read at a time.
// PARAMETERS
//  AXI_ADDR_WIDTH  32           address width
//  AXI_DATA_WIDTH  32           data width (32 only); AXI_STRB_WIDTH = AXI_DATA_WIDTH/8
//  MEM_DEPTH       1024         number of 32-bit words; power of two
//  BASE_ADDR       32'h0000_0000  byte base of the window; word-aligned
// PORTS
//  ACLK      in   1   AXI clock; all logic on rising edge
//  ARESETn   in   1   reset, asynchronous, active-low
//  AWVALID   in   1   write address valid
//  AWREADY   out  1   write address ready
//  AWADDR    in   AW  write byte address
//  AWPROT    in   3   ignored
//  WVALID    in   1   write data valid
//  WREADY    out  1   write data ready
//  WDATA     in   32  write data
//  WSTRB     in   4   byte lane enables
//  BVALID    out  1   write response valid
//  BREADY    in   1   write response ready
//  BRESP     out  2   2'b00 OKAY, 2'b10 SLVERR
//  ARVALID   in   1   read address valid
//  ARREADY   out  1   read address ready
//  ARADDR    in   AW  read byte address
//  ARPROT    in   3   ignored
//  RVALID    out  1   read data valid
//  RREADY    in   1   read data ready
//  RDATA     out  32  read data
//  RRESP     out  2   2'b00 OKAY, 2'b10 SLVERR
// BEHAVIOUR
//  Reset: AWREADY=WREADY=ARREADY=1; BVALID=RVALID=0; BRESP=RRESP=2'b00; RDATA=0; both FSMs
//   in IDLE; latched AW/W cleared. Memory contents not reset. Reset mid-transaction aborts it:
//   no memory update unless the write edge already occurred.
//  Decode: off=ADDR-BASE_ADDR; in range iff ADDR>=BASE_ADDR and off<MEM_DEPTH*4;
//   word index=off[log2(MEM_DEPTH)+1:2]; off[1:0] ignored.
//  Write FSM W_IDLE -> W_RESP:
//   - AW and W accepted independently, either order or same cycle. AWREADY=1 while in W_IDLE
//     and no address latched; WREADY=1 while in W_IDLE and no data latched.
//   - On the edge where both are held (or the second arrives): in range -> write lanes with
//     WSTRB[i]=1, BRESP=00; out of range -> no write, BRESP=10. Same edge sets BVALID=1,
//     enters W_RESP, clears latches. Latency: BVALID 1 cycle after the later handshake.
//   - W_RESP: AWREADY=WREADY=0; BVALID/BRESP held until BVALID&&BREADY, then W_IDLE,
//     BVALID=0, BRESP=00, readys=1 next cycle. WSTRB=0 in range: OKAY, memory unchanged.
//  Read FSM R_IDLE -> R_DATA:
//   - ARREADY=1 only in R_IDLE. On ARVALID&&ARREADY: RDATA=mem[index] (in range, RRESP=00)
//     or 32'h0 (out of range, RRESP=10); RVALID=1 next cycle; enter R_DATA.
//   - R_DATA: RDATA/RRESP/RVALID stable until RVALID&&RREADY; then R_IDLE, RVALID=0, RDATA=0,
//     RRESP=00. RREADY held high: back-to-back reads every 2 cycles.
//  Collision: read capture and write commit on same edge, same word -> read returns OLD data.
//  Write and read engines never block each other.
// TESTING
//  1 AW(0x10) then W(0xDEADBEEF,strb 4'hF) 2 cycles later -> BVALID 1 cycle after W, BRESP=00;
//    read 0x10 -> RDATA=0xDEADBEEF, RRESP=00, RVALID 1 cycle after AR handshake.
//  2 W before AW, and AW+W same cycle, strb 4'b0101 data 0x11223344 over 0xDEADBEEF ->
//    readback 0xDE22BE44 in both cases.
//  3 write/read at BASE_ADDR+MEM_DEPTH*4 -> BRESP=10 and no memory change; RRESP=10, RDATA=0.
//  4 BREADY/RREADY held low 5 cycles -> BVALID/RVALID, BRESP/RDATA stable; AWREADY/WREADY
//    low during W_RESP; ARREADY low during R_DATA.
//  5 same-edge write commit and read capture to 0x20 (old 0x1, new 0x2) -> read returns 0x1,
//    next read 0x2.
//  6 ARESETn low while BVALID=1 and while W latched -> BVALID=0, readys=1; no write committed.

Source files
------------

// File: rtl/axi_lite_slave_mem_if.sv
// axi_lite_slave_mem_if: AXI4-lite AW/W/B/AR/R channel bundle between a CPU-side master and the memory slave.
//  Parameters: AXI_ADDR_WIDTH (address width), AXI_DATA_WIDTH (data width; strobe width is data/8).
//  Write address: AWVALID, AWREADY, AWADDR, AWPROT
//  Write data:    WVALID, WREADY, WDATA, WSTRB
//  Write resp:    BVALID, BREADY, BRESP
//  Read address:  ARVALID, ARREADY, ARADDR, ARPROT
//  Read data:     RVALID, RREADY, RDATA, RRESP
//  Modports: master drives requests, slave drives readys/responses.
interface axi_lite_slave_mem_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
);
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
    logic                      AWVALID;
    logic                      AWREADY;
    logic [AXI_ADDR_WIDTH-1:0] AWADDR;
    logic [2:0]                AWPROT;
    logic                      WVALID;
    logic                      WREADY;
    logic [AXI_DATA_WIDTH-1:0] WDATA;
    logic [AXI_STRB_WIDTH-1:0] WSTRB;
    logic                      BVALID;
    logic                      BREADY;
    logic [1:0]                BRESP;
    logic                      ARVALID;
    logic                      ARREADY;
    logic [AXI_ADDR_WIDTH-1:0] ARADDR;
    logic [2:0]                ARPROT;
    logic                      RVALID;
    logic                      RREADY;
    logic [AXI_DATA_WIDTH-1:0] RDATA;
    logic [1:0]                RRESP;

    modport master (
        output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi_lite_slave_mem.sv
// axi_lite_slave_mem: AXI4-lite slave terminating all five channels onto an on-chip word memory.
//  ACLK    in  clock, rising edge
//  ARESETn in  asynchronous active-low reset (memory contents are not reset)
//  s_axi   slave modport of axi_lite_slave_mem_if (AW/W/B/AR/R channels)
//  Window: BASE_ADDR .. BASE_ADDR+MEM_DEPTH*4-1; outside it writes are dropped with SLVERR
//  and reads return zero with SLVERR. One outstanding write and one outstanding read.
module axi_lite_slave_mem #(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        MEM_DEPTH      = 1024,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input logic                  ACLK,
    input logic                  ARESETn,
    axi_lite_slave_mem_if.slave  s_axi
);
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] WIN_BYTES = AXI_ADDR_WIDTH'(MEM_DEPTH * 4);

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
        return (a >= BASE_ADDR) && ((a - BASE_ADDR) < WIN_BYTES);
    endfunction

    // Byte offset bits [1:0] are dropped; only the word index selects the entry.
    function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    logic unused_prot;
    assign unused_prot = ^{s_axi.AWPROT, s_axi.ARPROT};

    w_state_t                  w_state, w_next;
    logic                      aw_held, w_held;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [AXI_DATA_WIDTH-1:0] w_data_q;
    logic [AXI_STRB_WIDTH-1:0] w_strb_q;
    logic [1:0]                bresp_q;
    logic                      aw_fire, w_fire, b_fire, commit, wr_ok;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [AXI_DATA_WIDTH-1:0] wr_data;
    logic [AXI_STRB_WIDTH-1:0] wr_strb;

    assign s_axi.AWREADY = (w_state == W_IDLE) && !aw_held;
    assign s_axi.WREADY  = (w_state == W_IDLE) && !w_held;
    assign s_axi.BVALID  = (w_state == W_RESP);
    assign s_axi.BRESP   = bresp_q;

    // A channel arriving this cycle is used directly, so the commit happens on the
    // same edge as the later of the two handshakes.
    always_comb begin
        aw_fire = s_axi.AWVALID && s_axi.AWREADY;
        w_fire  = s_axi.WVALID && s_axi.WREADY;
        b_fire  = s_axi.BVALID && s_axi.BREADY;
        wr_addr = aw_held ? aw_addr_q : s_axi.AWADDR;
        wr_data = w_held ? w_data_q : s_axi.WDATA;
        wr_strb = w_held ? w_strb_q : s_axi.WSTRB;
        commit  = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
        wr_ok   = in_range(wr_addr);
        w_next  = (w_state == W_IDLE) ? (commit ? W_RESP : W_IDLE) : (b_fire ? W_IDLE : W_RESP);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state   <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= 2'b00;
        end else begin
            w_state <= w_next;
            aw_held <= !commit && (aw_held || aw_fire);
            w_held  <= !commit && (w_held || w_fire);
            if (aw_fire)
                aw_addr_q <= s_axi.AWADDR;
            if (w_fire) begin
                w_data_q <= s_axi.WDATA;
                w_strb_q <= s_axi.WSTRB;
            end
            if (commit)
                bresp_q <= wr_ok ? 2'b00 : 2'b10;
            else if (b_fire)
                bresp_q <= 2'b00;
        end
    end

    // ARESETn gate keeps a master that holds valids during reset from writing memory.
    always_ff @(posedge ACLK) begin
        if (commit && wr_ok && ARESETn)
            for (int i = 0; i < AXI_STRB_WIDTH; i++)
                if (wr_strb[i])
                    mem[word_idx(wr_addr)][8*i +: 8] <= wr_data[8*i +: 8];
    end

    r_state_t                  r_state, r_next;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                rresp_q;
    logic                      ar_fire, r_fire;

    assign s_axi.ARREADY = (r_state == R_IDLE);
    assign s_axi.RVALID  = (r_state == R_DATA);
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = rresp_q;

    always_comb begin
        ar_fire = s_axi.ARVALID && s_axi.ARREADY;
        r_fire  = s_axi.RVALID && s_axi.RREADY;
        r_next  = (r_state == R_IDLE) ? (ar_fire ? R_DATA : R_IDLE) : (r_fire ? R_IDLE : R_DATA);
    end

    // The capture reads mem before any same-edge write lands, so a colliding read sees old data.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= 2'b00;
        end else begin
            r_state <= r_next;
            if (ar_fire) begin
                rdata_q <= in_range(s_axi.ARADDR) ? mem[word_idx(s_axi.ARADDR)] : '0;
                rresp_q <= in_range(s_axi.ARADDR) ? 2'b00 : 2'b10;
            end else if (r_fire) begin
                rdata_q <= '0;
                rresp_q <= 2'b00;
            end
        end
    end
endmodule
